// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8-bit LSB-first serial transmitter.
// Bytes enter a power-of-two FIFO over a valid/ready handshake and leave as
// start / 8 data / STOP_BITS stop frames on txd, back-to-back while queued.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bits.
module uart_tx_fifo #(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD      = 115200,
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     txd,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(DEPTH);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  logic       push;
  logic       pop;
  logic       bit_end;
  logic       fifo_empty;
  logic [7:0] head;

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid & in_ready;
  assign bit_end    = (cnt_q == CNT_LAST);
  assign head       = mem_q[rd_ptr_q];
  // A byte leaves the FIFO either from idle or on the very last stop-bit
  // cycle, so consecutive frames follow each other with no idle gap.
  assign pop        = !fifo_empty &&
                      ((state_q == IDLE) ||
                       (state_q == STOP && bit_end && bit_q == STOP_LAST));

  assign txd        = txd_q;
  assign busy       = (state_q != IDLE) | !fifo_empty;
  assign fifo_count = count_q;

  // FIFO storage: written on every accepted byte.
  // NOTE: the data array has no reset; only pointers and count define validity,
  // and leaving it unreset lets it map onto plain RAM/registers without reset muxes.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame sequencer with registered line output: txd_q always carries the
  // level of the state being entered, so txd never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q  <= head;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^head;
`endif
            txd_q    <= 1'b0;
            state_q  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
              txd_q   <= parity_q;
              state_q <= PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            txd_q   <= 1'b1;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (pop) begin
                shift_q  <= head;
`ifdef UART_TX_PARITY_EN
                parity_q <= ^head;
`endif
                txd_q    <= 1'b0;
                state_q  <= START;
              end else begin
                txd_q    <= 1'b1;
                state_q  <= IDLE;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: two transmitter lanes (1 and 2 stop bits, DIV=10, DEPTH=4)
// checked cycle by cycle against a frame-level queue model, plus directed
// checks for launch latency, bit levels, frame length, backpressure,
// push/pop coincidence and asynchronous reset. Honours UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DIV      = 10;
  localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data    [2];
  logic       in_valid   [2];
  logic       in_ready   [2];
  logic       txd        [2];
  logic       busy       [2];
  logic [2:0] fifo_count [2];

  int   n_checks = 0;
  int   n_errors = 0;
  int   peak;
  logic saw_full;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    uart_tx_fifo #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .DEPTH    (DEPTH),
      .STOP_BITS(g + 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .txd       (txd[g]),
      .busy      (busy[g]),
      .fifo_count(fifo_count[g])
    );

    // Reference: a byte queue plus the list of line levels still to be sent.
    logic [7:0] q[$];
    logic       wave[$];
    logic       m_txd  = 1'b1;
    logic       m_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
      logic       push_ok;
      logic       in_frame;
      logic [7:0] b;
      if (!rst_n) begin
        q.delete();
        wave.delete();
        m_txd  = 1'b1;
        m_busy = 1'b0;
      end else begin
        push_ok = in_valid[g] && (q.size() != DEPTH);
        if (wave.size() == 0 && q.size() != 0) begin
          b = q.pop_front();
          for (int i = 0; i < DIV; i++) wave.push_back(1'b0);
          for (int j = 0; j < 8; j++)
            for (int i = 0; i < DIV; i++) wave.push_back(b[j]);
          if (PAR != 0)
            for (int i = 0; i < DIV; i++) wave.push_back(^b);
          for (int i = 0; i < (g + 1) * DIV; i++) wave.push_back(1'b1);
        end
        in_frame = (wave.size() != 0);
        m_txd    = in_frame ? wave.pop_front() : 1'b1;
        if (push_ok) q.push_back(in_data[g]);
        m_busy   = in_frame || (q.size() != 0);
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        check($sformatf("txd%0d", g), 32'(txd[g]), 32'(m_txd));
        check($sformatf("busy%0d", g), 32'(busy[g]), 32'(m_busy));
        check($sformatf("count%0d", g), 32'(fifo_count[g]), 32'(q.size()));
        check($sformatf("ready%0d", g), 32'(in_ready[g]), 32'(q.size() != DEPTH));
      end
    end
  end

  task automatic track(input int k);
    if (32'(fifo_count[k]) > peak) peak = 32'(fifo_count[k]);
    if (!in_ready[k]) saw_full = 1'b1;
  endtask

  // Presents one byte and returns just after the edge that accepts it.
  task automatic push_byte(input int k, input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = b;
    track(k);
    while (!in_ready[k] && guard < 5000) begin
      @(negedge clk);
      guard++;
      track(k);
    end
    if (guard >= 5000) check("push_timeout", 32'd1, 32'd0);
    @(posedge clk);
  endtask

  task automatic drop_valid(input int k);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy[k] && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Single frame from idle: launch latency, mid-bit levels, frame length.
  task automatic run_single(input int k, input logic [7:0] b);
    int n;
    int idx;
    logic exp;
    wait_idle(k);
    push_byte(k, b);
    @(negedge clk);
    in_valid[k] = 1'b0;
    check("pre_launch", 32'(txd[k]), 32'd1);
    @(negedge clk);
    check("launch", 32'(txd[k]), 32'd0);
    n = 0;
    while (busy[k] && n < 2000) begin
      @(negedge clk);
      n++;
      if (n % DIV == DIV / 2) begin
        idx = n / DIV;
        if (idx == 0)                   exp = 1'b0;
        else if (idx <= 8)              exp = b[idx-1];
        else if (PAR != 0 && idx == 9)  exp = ^b;
        else                            exp = 1'b1;
        if (busy[k]) check($sformatf("level%0d_%0d", k, idx), 32'(txd[k]), 32'(exp));
      end
    end
    check($sformatf("frame_len%0d", k), 32'(n), 32'((10 + k + PAR) * DIV));
  endtask

  initial begin
    int f;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_txd", 32'(txd[k]), 32'd1);
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_count", 32'(fifo_count[k]), 32'd0);
      check("rst_ready", 32'(in_ready[k]), 32'd1);
    end
    rst_n = 1'b1;

    // Basic frames: 8N1 with 0x55, 8N2 with 0xA3, parity-sensitive bytes.
    run_single(0, 8'h55);
    run_single(1, 8'hA3);
    run_single(0, 8'h07);
    run_single(1, 8'h03);

    // Backpressure: stream eight bytes with valid held high.
    for (int k = 0; k < 2; k++) begin
      wait_idle(k);
      peak     = 0;
      saw_full = 1'b0;
      for (int i = 0; i < 8; i++) push_byte(k, 8'(8'h10 + i));
      drop_valid(k);
      check("peak", 32'(peak), 32'(DEPTH));
      check("saw_full", 32'(saw_full), 32'd1);
    end

    // Push on the final stop cycle while one byte is queued.
    for (int k = 0; k < 2; k++) begin
      wait_idle(k);
      f = (10 + k + PAR) * DIV;
      push_byte(k, 8'($urandom));
      push_byte(k, 8'($urandom));
      @(negedge clk);
      in_valid[k] = 1'b0;
      repeat (f - 1) @(negedge clk);
      check("pp_pre", 32'(fifo_count[k]), 32'd1);
      in_valid[k] = 1'b1;
      in_data[k]  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      in_valid[k] = 1'b0;
      check("pp_count", 32'(fifo_count[k]), 32'd1);
      check("pp_start", 32'(txd[k]), 32'd0);
    end

    // Random traffic with gaps both shorter and longer than a frame.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20; i++) begin
        push_byte(k, 8'($urandom));
        drop_valid(k);
        repeat ($urandom_range(0, 150)) @(negedge clk);
      end
      wait_idle(k);
    end

    // Asynchronous reset in the middle of frames with a byte still queued.
    wait_idle(0);
    wait_idle(1);
    push_byte(0, 8'h00);
    push_byte(0, 8'h5A);
    drop_valid(0);
    push_byte(1, 8'h00);
    push_byte(1, 8'h5A);
    drop_valid(1);
    repeat (45) @(negedge clk);
    check("pre_rst_txd0", 32'(txd[0]), 32'd0);
    check("pre_rst_txd1", 32'(txd[1]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("arst_txd", 32'(txd[k]), 32'd1);
      check("arst_busy", 32'(busy[k]), 32'd0);
      check("arst_count", 32'(fifo_count[k]), 32'd0);
      check("arst_ready", 32'(in_ready[k]), 32'd1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy0", 32'(busy[0]), 32'd0);
    check("post_rst_busy1", 32'(busy[1]), 32'd0);
    run_single(0, 8'hC6);
    run_single(1, 8'h39);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
